// File: rtl/bytecode_prefetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bytecode_prefetch_sequencer
//  Description : Streams bytes from a 1-cycle-latency bytecode ROM and splits
//                them into variable-length instructions (opcode + operands).
//                Up to DEPTH assembled instructions are queued, and the head
//                is presented to the decoder over a start/ready handshake.
//
//  Ports
//    clk                 in   rising-edge clock
//    reset               in   synchronous, active-high reset
//    enable              in   fetch enable (0 = issue no new ROM reads)
//    rom_en              out  ROM read strobe
//    rom_address         out  ROM read address (holds when rom_en=0)
//    data_from_rom       in   byte for the address issued one cycle earlier
//    len_query_opcode    out  opcode being sized (= data_from_rom)
//    len_query_bytes     in   combinational total-length reply
//    start_for_decoder   out  instruction valid
//    ready_from_decoder  in   decoder accepts
//    data_for_decoder    out  packed instruction, byte k at [8k+7:8k]
//    instr_len           out  byte count of the presented instruction
//    jump_valid          in   redirect request      (PC_JUMP_EN only)
//    jump_address        in   redirect target       (PC_JUMP_EN only)
//
//  Optional feature macro : PC_JUMP_EN (adds the PC redirect ports)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bytecode_prefetch_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int MAX_BYTES = 3,
    parameter int DEPTH     = 4,
    parameter int LEN_W     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   rom_en,
    output logic [ADDR_W-1:0]      rom_address,
    input  logic [7:0]             data_from_rom,
    output logic [7:0]             len_query_opcode,
    input  logic [LEN_W-1:0]       len_query_bytes,
    output logic                   start_for_decoder,
    input  logic                   ready_from_decoder,
    output logic [8*MAX_BYTES-1:0] data_for_decoder,
    output logic [LEN_W-1:0]       instr_len
`ifdef PC_JUMP_EN
    ,
    input  logic                   jump_valid,
    input  logic [ADDR_W-1:0]      jump_address
`endif
);

    localparam int c_DATA_W = 8 * MAX_BYTES;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_PTR_W  = $clog2(DEPTH);

    localparam logic [0:0] c_ST_OPCODE  = 1'b0;
    localparam logic [0:0] c_ST_OPERAND = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic                r_inflight;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_DATA_W-1:0] r_bytes;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    r_remaining;

    logic [c_DATA_W-1:0] r_q_data [DEPTH];
    logic [LEN_W-1:0]    r_q_len  [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------
    // Redirect
    // ------------------------------------------------------------------
    logic w_jump;
`ifdef PC_JUMP_EN
    assign w_jump = jump_valid;
`else
    assign w_jump = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Fetch: a slot is reserved for the instruction being assembled (or
    // whose byte is still in flight), so a read is issued only when the
    // queue is guaranteed to have room for its result.
    // ------------------------------------------------------------------
    logic              w_open;
    logic              w_room;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_open = r_inflight | (r_state == c_ST_OPERAND);
    assign w_room = (int'(r_count) + int'(w_open)) < DEPTH;

    assign rom_en      = ~reset & enable & w_room;
    assign rom_address = rom_en ? r_pc : r_addr_hold;

    always_comb begin
        w_pc_next = rom_en ? (r_pc + ADDR_W'(1)) : r_pc;
`ifdef PC_JUMP_EN
        if (jump_valid) begin
            w_pc_next = jump_address;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_addr_hold <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_inflight <= rom_en & ~w_jump;
            if (rom_en) begin
                r_addr_hold <= r_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Assembler FSM
    // ------------------------------------------------------------------
    assign len_query_opcode = data_from_rom;

    logic [LEN_W-1:0]    w_len_fix;
    logic [c_DATA_W-1:0] w_merged;
    logic                w_push;
    logic [c_DATA_W-1:0] w_push_data;
    logic [LEN_W-1:0]    w_push_len;

    // Lengths outside 1..MAX_BYTES are treated as single-byte opcodes.
    assign w_len_fix = ((len_query_bytes == '0) || (int'(len_query_bytes) > MAX_BYTES))
                     ? LEN_W'(1) : len_query_bytes;

    always_comb begin
        w_merged = r_bytes;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (int'(r_idx) == k) begin
                w_merged[8*k +: 8] = data_from_rom;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_data  = w_merged;
        w_push_len   = r_len;
        if (r_inflight) begin
            case (r_state)
                c_ST_OPCODE: begin
                    if (w_len_fix == LEN_W'(1)) begin
                        w_push      = 1'b1;
                        w_push_data = c_DATA_W'(data_from_rom);
                        w_push_len  = LEN_W'(1);
                    end else begin
                        w_state_next = c_ST_OPERAND;
                    end
                end
                c_ST_OPERAND: begin
                    if (r_remaining == LEN_W'(1)) begin
                        w_push       = 1'b1;
                        w_state_next = c_ST_OPCODE;
                    end
                end
                default: w_state_next = c_ST_OPCODE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_jump) begin
            r_state <= c_ST_OPCODE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bytes     <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
        end else if (r_inflight) begin
            if (r_state == c_ST_OPCODE) begin
                // Starting fresh clears the upper bytes so unused ones read 0.
                r_bytes     <= c_DATA_W'(data_from_rom);
                r_len       <= w_len_fix;
                r_idx       <= LEN_W'(1);
                r_remaining <= w_len_fix - LEN_W'(1);
            end else begin
                r_bytes     <= w_merged;
                r_idx       <= r_idx + LEN_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic w_pop;
    logic w_do_push;

    assign start_for_decoder = (r_count != '0);
    assign w_pop             = start_for_decoder & ready_from_decoder;
    assign w_do_push         = w_push & ~w_jump;

    assign data_for_decoder = start_for_decoder ? r_q_data[r_rd_ptr] : '0;
    assign instr_len        = start_for_decoder ? r_q_len[r_rd_ptr]  : '0;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : (p + c_PTR_W'(1));
    endfunction

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_q_data[r_wr_ptr] <= w_push_data;
            r_q_len[r_wr_ptr]  <= w_push_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_jump) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
